// File: rtl/sad_search_sequencer.sv
// Full-search controller for the pipelined SAD datapath: raster-issues candidates, tracks
// in-flight results and keeps the minimum. Optional SAD_EARLY_EXIT_EN stops on a zero SAD.
module sad_search_sequencer #(
    parameter int unsigned FRAME_W = 64,
    parameter int unsigned FRAME_H = 64,
    parameter int unsigned WIN     = 4,
    parameter int unsigned SAD_W   = 16,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    output logic             busy,
    output logic             done,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [31:0]      issue_addr,
    output logic [15:0]      cand_row,
    output logic [15:0]      cand_col,
    input  logic             res_valid,
    input  logic [SAD_W-1:0] res_sad,
    output logic [SAD_W-1:0] best_sad,
    output logic [15:0]      best_row,
    output logic [15:0]      best_col
);

    localparam int unsigned   OW      = $clog2(MAX_OUT + 1);
    localparam logic [OW-1:0] MaxOut  = OW'(MAX_OUT);
    localparam logic [15:0]   LastCol = 16'(FRAME_W - WIN);
    localparam logic [15:0]   LastRow = 16'(FRAME_H - WIN);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [31:0]   base_q;
    logic [OW-1:0] out_q, out_d;
    logic [15:0]   res_row_q, res_col_q;
    logic          xfer, res_take, last_pos, zero_exit;
    logic [15:0]   nxt_row, nxt_col;
    logic [31:0]   nxt_addr;

    always_comb begin
        xfer     = (state_q == StIssue) && issue_valid && issue_ready;
        // Results only count while a search owns them; stray pulses are dropped.
        res_take = res_valid && (out_q != '0) &&
                   ((state_q == StIssue) || (state_q == StDrain));
        last_pos = (cand_row == LastRow) && (cand_col == LastCol);

        if (cand_col == LastCol) begin
            nxt_col = 16'd0;
            nxt_row = cand_row + 16'd1;
        end else begin
            nxt_col = cand_col + 16'd1;
            nxt_row = cand_row;
        end
        nxt_addr = base_q + ((32'(nxt_row) * 32'(FRAME_W) + 32'(nxt_col)) << 2);

        out_d = out_q;
        unique case ({xfer, res_take})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

`ifdef SAD_EARLY_EXIT_EN
        zero_exit = res_take && (state_q == StIssue) && (res_sad == '0);
`else
        zero_exit = 1'b0;
`endif

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if ((xfer && last_pos) || zero_exit) state_d = StDrain;
            StDrain: if (out_d == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            out_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            issue_valid <= 1'b0;
            issue_addr  <= '0;
            cand_row    <= '0;
            cand_col    <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            best_sad    <= '1;
            best_row    <= '0;
            best_col    <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            busy        <= (state_d == StIssue) || (state_d == StDrain);
            done        <= (state_d == StDone);
            // Registered form of (state == ISSUE && outstanding < MAX_OUT).
            issue_valid <= (state_d == StIssue) && (out_d < MaxOut);

            if ((state_q == StIdle) && start) begin
                base_q     <= base_addr;
                issue_addr <= base_addr;
                cand_row   <= '0;
                cand_col   <= '0;
                res_row_q  <= '0;
                res_col_q  <= '0;
                best_sad   <= '1;
                best_row   <= '0;
                best_col   <= '0;
            end

            // The last candidate stays on the outputs once issued.
            if (xfer && !last_pos) begin
                cand_row   <= nxt_row;
                cand_col   <= nxt_col;
                issue_addr <= nxt_addr;
            end

            if (res_take) begin
                if (res_sad < best_sad) begin
                    best_sad <= res_sad;
                    best_row <= res_row_q;
                    best_col <= res_col_q;
                end
                if (res_col_q == LastCol) begin
                    res_col_q <= '0;
                    res_row_q <= res_row_q + 16'd1;
                end else begin
                    res_col_q <= res_col_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_search_sequencer.sv
// Directed bench for sad_search_sequencer with a 3-cycle in-order SAD datapath model.
module tb_sad_search_sequencer;

    localparam int unsigned SW = 16;

    logic          Clk = 1'b0;
    logic          Rst, start, issue_ready, res_valid;
    logic [31:0]   base_addr;
    logic [SW-1:0] res_sad;
    logic          busy, done, issue_valid;
    logic [31:0]   issue_addr;
    logic [15:0]   cand_row, cand_col, best_row, best_col;
    logic [SW-1:0] best_sad;

    sad_search_sequencer #(
        .FRAME_W(8), .FRAME_H(8), .WIN(4), .SAD_W(SW), .MAX_OUT(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .base_addr(base_addr), .busy(busy),
        .done(done), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_addr(issue_addr), .cand_row(cand_row), .cand_col(cand_col),
        .res_valid(res_valid), .res_sad(res_sad), .best_sad(best_sad),
        .best_row(best_row), .best_col(best_col)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        int          due;
    } ent_t;

    ent_t        pipe[$];
    int          cyc = 0;
    int          xfer_cnt, done_cnt, out_m, max_out, xfer_after_zero;
    bit          zero_seen, busy_at_done, res_stall;
    logic [31:0] addr23;
    int          mode;
    int          total = 0;
    int          bad = 0;

    function automatic logic [SW-1:0] sad_of(input logic [15:0] r, input logic [15:0] c);
        case (mode)
            0:       return (r == 3 && c == 1) ? SW'(7) : SW'(20 + r + c);
            1:       return ((r == 0 && c == 2) || (r == 4 && c == 4)) ? SW'(5) : SW'(9);
            default: return (r == 1 && c == 1) ? SW'(0) : SW'(9);
        endcase
    endfunction

    // Monitor: reads pre-edge values, i.e. what the DUT sampled at this edge.
    always @(posedge Clk) begin
        ent_t e;
        cyc++;
        if (!Rst) begin
            if (issue_valid && issue_ready) begin
                e.r = cand_row;
                e.c = cand_col;
                e.due = cyc + 3;
                pipe.push_back(e);
                xfer_cnt++;
                out_m++;
                if (cand_row == 2 && cand_col == 3) addr23 = issue_addr;
                if (zero_seen) xfer_after_zero++;
            end
            if (res_valid) out_m--;
            if (res_valid && res_sad == '0) zero_seen = 1'b1;
            if (out_m > max_out) max_out = out_m;
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
            end
        end
    end

    // Datapath model: presents each result for the edge three cycles after its transfer.
    always @(negedge Clk) begin
        res_valid = 1'b0;
        res_sad   = '0;
        if (Rst) begin
            pipe.delete();
        end else if (!res_stall && pipe.size() > 0 && pipe[0].due <= cyc + 1) begin
            res_valid = 1'b1;
            res_sad   = sad_of(pipe[0].r, pipe[0].c);
            void'(pipe.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        xfer_cnt = 0;
        done_cnt = 0;
        out_m = 0;
        max_out = 0;
        zero_seen = 1'b0;
        xfer_after_zero = 0;
        addr23 = 32'hDEAD_BEEF;
        busy_at_done = 1'b1;
    endtask

    task automatic start_search(input logic [31:0] base);
        clear_stats();
        base_addr = base;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_xfer(input int n, input string tag);
        int k = 0;
        while (xfer_cnt < n && k < 500) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, 32'(xfer_cnt), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 500) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [15:0] r, c;
        Rst = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        base_addr = '0;
        res_stall = 1'b0;
        mode = 0;
        clear_stats();

        // Reset values
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ivalid", 32'(issue_valid), 32'd0);
        chk("rst_best_sad", 32'(best_sad), 32'hFFFF);
        chk("rst_addr", issue_addr, 32'd0);
        chk("rst_cand", {cand_row, cand_col}, 32'd0);
        chk("rst_best_pos", {best_row, best_col}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Full search, minimum 7 at (3,1)
        issue_ready = 1'b1;
        start_search(32'h100);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ivalid", 32'(issue_valid), 32'd1);
        chk("start_addr", issue_addr, 32'h100);
        wait_done("full_done");
        chk("full_xfers", 32'(xfer_cnt), 32'd25);
        chk("full_addr23", addr23, 32'h14C);
        chk("full_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("full_best_sad", 32'(best_sad), 32'd7);
        chk("full_best_pos", {best_row, best_col}, {16'd3, 16'd1});
        repeat (3) @(negedge Clk);
        chk("full_done_once", 32'(done_cnt), 32'd1);
        chk("full_idle_busy", 32'(busy), 32'd0);
        chk("full_hold_sad", 32'(best_sad), 32'd7);
        chk("full_max_out", 32'(max_out <= 4), 32'd1);

        // Backpressure on issue, then a stalled datapath
        start_search(32'h200);
        wait_xfer(8, "bp_xfers");
        issue_ready = 1'b0;
        chk("bp_next_cand", {cand_row, cand_col}, {16'd1, 16'd3});
        chk("bp_next_addr", issue_addr, 32'h22C);
        a = issue_addr;
        r = cand_row;
        c = cand_col;
        repeat (10) @(negedge Clk);
        chk("bp_hold_addr", issue_addr, a);
        chk("bp_hold_cand", {cand_row, cand_col}, {r, c});
        chk("bp_out_zero", 32'(out_m), 32'd0);
        chk("bp_ivalid", 32'(issue_valid), 32'd1);
        res_stall = 1'b1;
        issue_ready = 1'b1;
        repeat (10) @(negedge Clk);
        chk("stall_ivalid", 32'(issue_valid), 32'd0);
        chk("stall_out", 32'(out_m), 32'd4);
        res_stall = 1'b0;
        wait_done("bp_done");
        chk("bp_total", 32'(xfer_cnt), 32'd25);
        chk("bp_max_out", 32'(max_out <= 4), 32'd1);
        chk("bp_best", {best_row, best_col}, {16'd3, 16'd1});
        chk("bp_best_sad", 32'(best_sad), 32'd7);

        // Ties keep the earliest, start while busy ignored
        mode = 1;
        @(negedge Clk);
        start_search(32'h0);
        repeat (5) @(negedge Clk);
        base_addr = 32'h5000;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("tie_busy", 32'(busy), 32'd1);
        wait_done("tie_done");
        repeat (3) @(negedge Clk);
        chk("tie_done_once", 32'(done_cnt), 32'd1);
        chk("tie_xfers", 32'(xfer_cnt), 32'd25);
        chk("tie_addr23", addr23, 32'h4C);
        chk("tie_best_sad", 32'(best_sad), 32'd5);
        chk("tie_best_pos", {best_row, best_col}, {16'd0, 16'd2});

        // Reset mid-search
        mode = 0;
        start_search(32'h100);
        wait_xfer(10, "mid_xfers");
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ivalid", 32'(issue_valid), 32'd0);
        chk("mid_best_sad", 32'(best_sad), 32'hFFFF);
        Rst = 1'b0;
        clear_stats();
        repeat (2) @(negedge Clk);
        chk("mid_idle_ivalid", 32'(issue_valid), 32'd0);
        start_search(32'h100);
        wait_done("mid_done");
        chk("mid_total", 32'(xfer_cnt), 32'd25);
        chk("mid_best", {best_row, best_col}, {16'd3, 16'd1});

        // Zero SAD at (1,1)
        mode = 2;
        @(negedge Clk);
        start_search(32'h0);
        wait_done("zero_done");
`ifdef SAD_EARLY_EXIT_EN
        chk("zero_after", 32'(xfer_after_zero), 32'd0);
        chk("zero_xfers", 32'(xfer_cnt), 32'd10);
`else
        chk("zero_xfers", 32'(xfer_cnt), 32'd25);
`endif
        chk("zero_best_sad", 32'(best_sad), 32'd0);
        chk("zero_best_pos", {best_row, best_col}, {16'd1, 16'd1});
        repeat (3) @(negedge Clk);
        chk("zero_done_once", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
